// File: rtl/rx_ins_sched_if.sv
// Bus between the instruction requesters, the scheduler and the rx configuration port.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface rx_ins_sched_if #(
  parameter int unsigned REQ_NUM = 4,
  parameter int unsigned INST_W  = 64
);
  logic                      sched_en;
  logic [REQ_NUM-1:0]        req_valid;
  logic [REQ_NUM-1:0]        req_ready;
  logic [REQ_NUM*INST_W-1:0] req_ins;
  logic                      ins_valid;
  logic                      ins_ready;
  logic [INST_W-1:0]         ins;
  logic                      rx_done_pulse;
  logic [3:0]                rx_done_opcode;
  logic [REQ_NUM-1:0]        req_done;
  logic                      busy;
  logic                      err;
  logic [15:0]               issue_cnt;

  modport master (
    output sched_en, req_valid, req_ins, ins_ready, rx_done_pulse, rx_done_opcode,
    input  req_ready, ins_valid, ins, req_done, busy, err, issue_cnt
  );

  modport slave (
    input  sched_en, req_valid, req_ins, ins_ready, rx_done_pulse, rx_done_opcode,
    output req_ready, ins_valid, ins, req_done, busy, err, issue_cnt
  );
endinterface

// File: rtl/rx_ins_sched.sv
// Round-robin scheduler sharing one rx configuration port among REQ_NUM requesters;
// one instruction in flight at a time, tracked until its completion pulse or a timeout.
module rx_ins_sched #(
  parameter int unsigned REQ_NUM = 4,
  parameter int unsigned INST_W  = 64,
  parameter int unsigned TIMEOUT = 65535
) (
  input logic           clk,
  input logic           rst,
  rx_ins_sched_if.slave bus
);
  localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [PTR_W-1:0]   w_owner_inc;
  logic [PTR_W:0]     w_sum;
  logic               w_gnt_found;
  logic               w_grant;
  logic               w_issue;
  logic               w_done;
  logic               w_timeout;
  logic               w_stray;
  logic [INST_W-1:0]  w_gnt_ins;
  logic [INST_W-1:0]  r_ins;
  logic [REQ_NUM-1:0] r_req_done;
  logic [REQ_NUM-1:0] w_req_ready;
  logic               w_ins_valid;
  logic               w_busy;
  logic               r_err;
  logic [15:0]        r_issue_cnt;
  logic [15:0]        r_wait_cnt;
  logic [15:0]        w_wait_inc;

  // First valid requester at or after r_rr_ptr, wrapping; w_sum never exceeds 2*REQ_NUM-2.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_sum       = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(REQ_NUM)) w_sum = w_sum - (PTR_W+1)'(REQ_NUM);
      if (!w_gnt_found && bus.req_valid[w_sum[PTR_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_sum[PTR_W-1:0];
      end
    end
  end

  assign w_gnt_ins   = bus.req_ins[w_gnt_idx*INST_W +: INST_W];
  assign w_grant     = (r_state == IDLE) && bus.sched_en && w_gnt_found && !rst;
  assign w_issue     = (r_state == ISSUE) && bus.ins_ready;
  assign w_wait_inc  = r_wait_cnt + 16'd1;
  assign w_done      = (r_state == WAIT) && bus.rx_done_pulse;
  // A completion in the same cycle as the limit wins over the timeout.
  assign w_timeout   = (r_state == WAIT) && !bus.rx_done_pulse && (w_wait_inc == 16'(TIMEOUT));
  assign w_stray     = (r_state != WAIT) && bus.rx_done_pulse;
  assign w_owner_inc = (r_owner == PTR_W'(REQ_NUM-1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_state_nxt = ISSUE;
      ISSUE:   if (bus.ins_ready) w_state_nxt = WAIT;
      WAIT:    if (w_done || w_timeout) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = '0;
    if (w_grant) w_req_ready[w_gnt_idx] = 1'b1;
    w_ins_valid = (r_state == ISSUE);
    w_busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_ins       <= '0;
      r_req_done  <= '0;
      r_err       <= 1'b0;
      r_issue_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_req_done <= '0;
      if (w_grant) begin
        r_ins   <= w_gnt_ins;
        r_owner <= w_gnt_idx;
      end
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 16'd1;
        r_wait_cnt  <= '0;
      end else if (r_state == WAIT) begin
        r_wait_cnt <= w_wait_inc;
      end
      if (w_done) begin
        r_req_done[r_owner] <= 1'b1;
        r_rr_ptr            <= w_owner_inc;
        if (bus.rx_done_opcode != r_ins[61:58]) r_err <= 1'b1;
      end
      if (w_timeout || w_stray) r_err <= 1'b1;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.ins_valid = w_ins_valid;
  assign bus.ins       = r_ins;
  assign bus.req_done  = r_req_done;
  assign bus.busy      = w_busy;
  assign bus.err       = r_err;
  assign bus.issue_cnt = r_issue_cnt;
endmodule

// File: doc/rx_ins_sched.md
RX_INS_SCHED -- requirements
Module: rx_ins_sched

Interface
REQ-001 Parameter REQ_NUM, default 4: number of instruction requesters sharing the rx configuration port.
REQ-002 Parameter INST_W, default 64: instruction width; opcode at [61:58], buf_id at [57:52].
REQ-003 Parameter TIMEOUT, default 65535: WAIT-state cycle limit before the error flag is raised.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sched_en  input  1  high permits new grants; low blocks new grants only.
REQ-007 req_valid  input  REQ_NUM  per-requester instruction valid.
REQ-008 req_ready  output  REQ_NUM  per-requester accept, one-hot or zero.
REQ-009 req_ins  input  REQ_NUM*INST_W  packed instructions; requester i occupies bits [i*INST_W +: INST_W].
REQ-010 ins_valid  output  1  instruction valid toward the rx configuration port.
REQ-011 ins_ready  input  1  rx configuration port ready.
REQ-012 ins  output  INST_W  instruction toward the rx configuration port.
REQ-013 rx_done_pulse  input  1  completion pulse from the rx configuration port.
REQ-014 rx_done_opcode  input  4  opcode of the completed instruction.
REQ-015 req_done  output  REQ_NUM  one-cycle completion pulse to the owning requester.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 err  output  1  sticky error flag.
REQ-018 issue_cnt  output  16  count of instructions issued downstream.

Function
REQ-019 The FSM SHALL have three states, IDLE, ISSUE and WAIT, with IDLE as the reset state.
REQ-020 IDLE: when sched_en=1 and req_valid!=0, the block SHALL grant exactly one requester by round-robin, searching from rr_ptr upward with wrap-around.
REQ-021 Grant: req_ready[g] SHALL be driven combinationally high in IDLE for the granted index only; on that cycle the block SHALL latch req_ins[g], the owner index g and the opcode, then go to ISSUE.
REQ-022 req_ready SHALL be all-zero in ISSUE and WAIT, and all-zero in IDLE when sched_en=0.
REQ-023 ISSUE: ins_valid=1 and ins SHALL equal the latched instruction, held stable until ins_ready=1.
REQ-024 On the ISSUE cycle with ins_ready=1, the block SHALL increment issue_cnt (16-bit, wraps 0xFFFF to 0) and go to WAIT.
REQ-025 ins_valid SHALL be 0 in IDLE and WAIT.
REQ-026 WAIT: on rx_done_pulse=1, the block SHALL pulse req_done[owner] for exactly one cycle on the next clock, set rr_ptr to (owner+1) mod REQ_NUM, and return to IDLE.
REQ-027 The earliest next grant SHALL be the cycle after the return to IDLE, so the minimum spacing between grants is 3 cycles plus the downstream latency.
REQ-028 On WAIT completion, if rx_done_opcode differs from the latched opcode, err SHALL be set; completion otherwise proceeds normally.
REQ-029 rx_done_pulse received in IDLE or ISSUE SHALL be ignored and SHALL set err.
REQ-030 A 16-bit wait counter SHALL clear on entry to WAIT and increment every WAIT cycle.
REQ-031 If the wait counter reaches TIMEOUT, the block SHALL set err, pulse no req_done, leave rr_ptr unchanged and return to IDLE.
REQ-032 If rx_done_pulse and the timeout occur in the same cycle, completion SHALL take priority and no timeout error is set.
REQ-033 sched_en falling during ISSUE or WAIT SHALL NOT abort the in-flight instruction.
REQ-034 Changes to req_valid or req_ins after the grant SHALL NOT affect the latched instruction.
REQ-035 err SHALL clear only on rst.

Reset
REQ-036 rst=1 SHALL force, on the next edge: state IDLE, rr_ptr=0, ins_valid=0, ins=0, req_done=0, busy=0, err=0, issue_cnt=0, wait counter=0.
REQ-037 Reset SHALL apply mid-operation, dropping any latched instruction with no req_done pulse; req_ready SHALL be 0 while rst=1.

Verification
REQ-038 Reset, then req_valid=4'b0101 held, ins_ready=1, done pulse 2 cycles after each issue -> grants alternate 0,2,0,2; req_done[0] and req_done[2] each pulse once per grant.
REQ-039 All four requesters valid continuously -> grant order 0,1,2,3,0; issue_cnt=5 after five completions.
REQ-040 Grant requester 1, hold ins_ready=0 for 10 cycles -> ins_valid stays 1 with stable ins; issue occurs on the ins_ready=1 cycle.
REQ-041 TIMEOUT=20, no rx_done_pulse -> err=1 after 20 WAIT cycles; no req_done; next grant starts from the same rr_ptr.
REQ-042 Latched opcode 4'h2, completion with rx_done_opcode=4'h3 -> err=1 and req_done still pulses; a stray rx_done_pulse in IDLE -> err=1.
REQ-043 rst asserted during WAIT -> all outputs reset per REQ-036; a subsequent request from requester 3 is granted normally.
